// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Channel state encoding and minimum legal divisor.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } chan_state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: state, counter, active/shadow divisor.
// Divisor switches only at a period wrap so clk_out never glitches.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_we,
  input  logic [DIV_W-1:0] load_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  chan_state_t      state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] div_a, div_a_n;
  logic [DIV_W-1:0] div_s, div_s_n;
  logic             pend_n;
  logic             wrap;
  logic             run_n;
  logic [DIV_W:0]   half_n;
  logic             clk_n;
  logic             tick_n;

  // Next state, counter, divisor and the outputs of the next cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_a_n = div_a;
    div_s_n = div_s;
    pend_n  = pending;
    wrap    = (cnt == div_a - 1'b1);
    case (state)
      IDLE: begin
        if (pending) begin
          div_a_n = div_s;
          pend_n  = 1'b0;
        end
        if (en) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      default: begin
        if (wrap) begin
          cnt_n   = '0;
          state_n = en ? RUN : IDLE;
          if (pending) begin
            div_a_n = div_s;
            pend_n  = 1'b0;
          end
        end else begin
          cnt_n   = cnt + 1'b1;
          state_n = en ? RUN : STOPPING;
        end
      end
    endcase
    if (load_we) begin
      div_s_n = load_div;
      pend_n  = 1'b1;
    end
    run_n  = (state_n != IDLE);
    half_n = ({1'b0, div_a_n} + 1'b1) >> 1;
    clk_n  = run_n && ({1'b0, cnt_n} < half_n);
    tick_n = run_n && (cnt_n == '0);
  end

  // Channel registers; clk_out and tick come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div_a   <= DIV_W'(DEFAULT_DIV);
      div_s   <= DIV_W'(DEFAULT_DIV);
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_a   <= div_a_n;
      div_s   <= div_s_n;
      pending <= pend_n;
      clk_out <= clk_n;
      tick    <= tick_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/clk_div_multi.sv
// Bank of independent clock-divider channels with one load port.
// Load decode, legality check and error pulse live here.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int DIV_W       = 8,
  parameter  int DEFAULT_DIV = 4,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              load_valid,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [DIV_W-1:0]  load_div,
  output logic              load_ready,
  output logic              load_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] pending;
  logic              ch_ok;
  logic              div_ok;
  logic              accept;

  // Ready follows the addressed channel; unknown channels always accept.
  always_comb begin
    load_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(load_ch) == i) load_ready = !pending[i];
    end
  end

  assign ch_ok  = (int'(load_ch) < NUM_CH);
  assign div_ok = (load_div >= DIV_W'(MIN_DIV));
  assign accept = load_valid && load_ready;

  // Illegal accepted load pulses load_err for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) load_err <= 1'b0;
    else       load_err <= accept && !(ch_ok && div_ok);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic we;
    assign we = accept && ch_ok && div_ok && (int'(load_ch) == g);
    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (en[g]),
      .load_we  (we),
      .load_div (load_div),
      .pending  (pending[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g]),
      .busy     (busy[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed testbench for clk_div_multi (three channels, 8-bit divisors).
// Inputs change and outputs are sampled on the falling edge.
module tb_clk_div_multi;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 2;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] en;
  logic              load_valid;
  logic [CH_W-1:0]   load_ch;
  logic [DIV_W-1:0]  load_div;
  logic              load_ready;
  logic              load_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_div   (load_div),
    .load_ready (load_ready),
    .load_err   (load_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b1;
    en = '0;
    load_valid = 1'b0;
    load_ch = '0;
    load_div = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (clk_out !== 3'b000) begin
      errors++; $display("FAIL reset_clk_out got %b exp 000", clk_out);
    end
    checks++;
    if (tick !== 3'b000) begin
      errors++; $display("FAIL reset_tick got %b exp 000", tick);
    end
    checks++;
    if (busy !== 3'b000) begin
      errors++; $display("FAIL reset_busy got %b exp 000", busy);
    end
    checks++;
    if (load_err !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_load got err=%b rdy=%b exp 0 1", load_err, load_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 3'b000 || clk_out !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b clk=%b exp 000", busy, clk_out);
    end
  endtask

  task automatic test_default_div;
    logic e;
    en[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = ((k % 4) < 2);
      checks++;
      if (clk_out[0] !== e) begin
        errors++; $display("FAIL n4_clk k=%0d got %b exp %b", k, clk_out[0], e);
      end
      e = ((k % 4) == 0);
      checks++;
      if (tick[0] !== e || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL n4_tick k=%0d got tick=%b busy=%b exp %b 1", k, tick[0], busy[0], e);
      end
    end
  endtask

  task automatic test_load_switch;
    logic e;
    repeat (2) @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL sw_ready_before got %b exp 1", load_ready);
    end
    load_valid = 1'b1; load_ch = 2'd0; load_div = 8'd3;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0 || clk_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL sw_cnt2 got rdy=%b clk=%b exp 0 0", load_ready, clk_out[0]);
    end
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b0 || clk_out[0] !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL sw_cnt3 got rdy=%b clk=%b err=%b exp 0 0 0", load_ready, clk_out[0], load_err);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (load_ready !== 1'b1) begin
          errors++; $display("FAIL sw_ready_after got %b exp 1", load_ready);
        end
      end
      e = ((k % 3) < 2);
      checks++;
      if (clk_out[0] !== e) begin
        errors++; $display("FAIL n3_clk k=%0d got %b exp %b", k, clk_out[0], e);
      end
      e = ((k % 3) == 0);
      checks++;
      if (tick[0] !== e) begin
        errors++; $display("FAIL n3_tick k=%0d got %b exp %b", k, tick[0], e);
      end
    end
  endtask

  task automatic test_stop;
    logic ec;
    logic eb;
    load_valid = 1'b1; load_ch = 2'd1; load_div = 8'd6;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++; $display("FAIL idle_load_pending got %b exp 0", load_ready);
    end
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1 || busy[1] !== 1'b0 || clk_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL idle_load_done got rdy=%b busy=%b clk=%b exp 1 0 0", load_ready, busy[1], clk_out[1]);
    end
    en[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (clk_out[1] !== 1'b1 || tick[1] !== 1'b1) begin
      errors++;
      $display("FAIL stop_start got clk=%b tick=%b exp 1 1", clk_out[1], tick[1]);
    end
    @(negedge clk);
    en[1] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      ec = (k == 0);
      eb = (k < 4);
      checks++;
      if (clk_out[1] !== ec || busy[1] !== eb || tick[1] !== 1'b0) begin
        errors++;
        $display("FAIL stop_k%0d got clk=%b busy=%b tick=%b exp %b %b 0", k, clk_out[1], busy[1], tick[1], ec, eb);
      end
    end
  endtask

  task automatic test_load_err;
    logic e;
    logic found;
    load_valid = 1'b1; load_ch = 2'd0; load_div = 8'd1;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (load_err !== 1'b1) begin
      errors++; $display("FAIL err_div1 got %b exp 1", load_err);
    end
    @(negedge clk);
    checks++;
    if (load_err !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_div1_clear got err=%b rdy=%b exp 0 1", load_err, load_ready);
    end
    load_valid = 1'b1; load_ch = 2'd3; load_div = 8'd7;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (load_err !== 1'b1) begin
      errors++; $display("FAIL err_ch got %b exp 1", load_err);
    end
    @(negedge clk);
    load_ch = 2'd0;
    checks++;
    if (load_err !== 1'b0) begin
      errors++; $display("FAIL err_ch_clear got %b exp 0", load_err);
    end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (tick[0]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL err_sync got no tick exp tick");
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      e = ((k % 3) < 2);
      checks++;
      if (clk_out[0] !== e || tick[0] !== ((k % 3) == 0)) begin
        errors++;
        $display("FAIL err_keep_n3 k=%0d got clk=%b tick=%b exp %b", k, clk_out[0], tick[0], e);
      end
    end
    checks++;
    if (busy[1] !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_state got busy1=%b rdy=%b exp 0 1", busy[1], load_ready);
    end
  endtask

  task automatic test_div2;
    logic found;
    logic e;
    load_valid = 1'b1; load_ch = 2'd0; load_div = 8'd2;
    @(negedge clk);
    load_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (load_ready) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found || clk_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
      errors++;
      $display("FAIL n2_switch got found=%b clk=%b tick=%b exp 1 1 1", found, clk_out[0], tick[0]);
    end
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      e = ((k % 2) == 0);
      checks++;
      if (clk_out[0] !== e || tick[0] !== e) begin
        errors++;
        $display("FAIL n2_k%0d got clk=%b tick=%b exp %b", k, clk_out[0], tick[0], e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic found;
    logic e;
    load_valid = 1'b1; load_ch = 2'd1; load_div = 8'd5;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    en[1] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (tick[1]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL n5_sync got no tick exp tick");
    end
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      e = ((k % 5) < 3);
      checks++;
      if (clk_out[1] !== e || tick[1] !== ((k % 5) == 0)) begin
        errors++;
        $display("FAIL n5_k%0d got clk=%b tick=%b exp %b", k, clk_out[1], tick[1], e);
      end
    end
    checks++;
    if (clk_out[1:0] === 2'b00) begin
      errors++; $display("FAIL pre_reset got clk=%b exp nonzero", clk_out[1:0]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (clk_out !== 3'b000 || tick !== 3'b000 || busy !== 3'b000 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got clk=%b tick=%b busy=%b err=%b exp 0", clk_out, tick, busy, load_err);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = (k < 2);
      checks++;
      if (clk_out[1:0] !== {e, e} || tick[1:0] !== {2{k == 0}}) begin
        errors++;
        $display("FAIL restart_k%0d got clk=%b tick=%b exp %b%b", k, clk_out[1:0], tick[1:0], e, e);
      end
    end
  endtask

  task automatic test_wrap_load;
    logic e0;
    logic t0;
    logic e1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_ready got %b exp 1", load_ready);
    end
    load_valid = 1'b1; load_ch = 2'd0; load_div = 8'd6;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      if (k < 4) begin
        e0 = (k < 2);
        t0 = (k == 0);
      end else begin
        e0 = (((k - 4) % 6) < 3);
        t0 = (((k - 4) % 6) == 0);
      end
      e1 = ((k % 4) < 2);
      checks++;
      if (clk_out[0] !== e0 || tick[0] !== t0 || clk_out[1] !== e1) begin
        errors++;
        $display("FAIL wrap_k%0d got c0=%b t0=%b c1=%b exp %b %b %b", k, clk_out[0], tick[0], clk_out[1], e0, t0, e1);
      end
    end
  endtask

  task automatic test_max_div;
    logic found;
    int   period;
    int   highs;
    load_valid = 1'b1; load_ch = 2'd2; load_div = 8'd255;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    en[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (tick[2] !== 1'b1 || clk_out[2] !== 1'b1) begin
      errors++;
      $display("FAIL max_start got tick=%b clk=%b exp 1 1", tick[2], clk_out[2]);
    end
    period = 1;
    highs = clk_out[2] ? 1 : 0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (tick[2]) found = 1'b1;
      else begin
        period++;
        if (clk_out[2]) highs++;
      end
    end
    checks++;
    if (!found || period != 255 || highs != 128) begin
      errors++;
      $display("FAIL max_period got found=%b period=%0d highs=%0d exp 1 255 128", found, period, highs);
    end
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_load_switch();
    test_stop();
    test_load_err();
    test_div2();
    test_reset_mid();
    test_wrap_load();
    test_max_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
